// File: rtl/fifo_uart_drain_pkg.sv
// Shared types and constants for the FIFO-to-UART drain sequencer.
package fifo_uart_pkg;

    localparam int         BYTE_CNT_W    = 16;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        WAIT_HI,
        WAIT_LO,
        SYNC
    } drain_state_t;

endpackage

// File: rtl/fifo_uart_drain_if.sv
// FIFO read side, UART transmitter side and status signals of the drain sequencer.
interface fifo_uart_drain_if
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W = 8
) ();

    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_W-1:0]     fifo_q;
    logic                  fifo_rdreq;
    logic                  tx_busy;
    logic [DATA_W-1:0]     tx_data;
    logic                  tx_wr_en;
    logic [BYTE_CNT_W-1:0] byte_count;
    logic                  err_timeout;
    logic                  active;

    modport master (
        input  enable, fifo_empty, fifo_q, tx_busy,
        output fifo_rdreq, tx_data, tx_wr_en, byte_count, err_timeout, active
    );

    modport slave (
        output enable, fifo_empty, fifo_q, tx_busy,
        input  fifo_rdreq, tx_data, tx_wr_en, byte_count, err_timeout, active
    );

endinterface

// File: rtl/fifo_uart_drain_timeout_ctr.sv
// Loadable down-counter; o_expired marks the last counted cycle after a load.
module drain_timeout_ctr #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from a FIFO read port and hands each to a UART transmitter, one at a time.
// Define FIFO_UART_DRAIN_SYNC_EN to insert SYNC_BYTE ahead of every GROUP_LEN data bytes.
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int RD_LATENCY   = 1,
    parameter int BUSY_TIMEOUT = 64
`ifdef FIFO_UART_DRAIN_SYNC_EN
    ,
    parameter int                GROUP_LEN = 4,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_BYTE_DEF)
`endif
) (
    input  logic              clk_50m,
    input  logic              clr,
    fifo_uart_drain_if.master drain
);

    localparam int         TO_W     = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    drain_state_t          r_state;
    logic                  r_rdreq;
    logic                  r_wr_en;
    logic                  r_err;
    logic                  r_active;
    logic [DATA_W-1:0]     r_tx_data;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [1:0]            r_lat_cnt;

    logic                  w_start;
    logic                  w_need_sync;
    logic                  w_to_load;
    logic                  w_to_dec;
    logic                  w_to_expired;

    assign w_start   = drain.enable && !drain.fifo_empty && !drain.tx_busy;
    assign w_to_load = (r_state == SEND);
    assign w_to_dec  = (r_state == WAIT_HI);

`ifdef FIFO_UART_DRAIN_SYNC_EN
    localparam logic [1:0] GRP_LAST = 2'(GROUP_LEN - 1);

    logic [1:0] r_grp_idx;
    logic       r_sync_done;

    // The delimiter goes out once per group, just before the group's first pop.
    assign w_need_sync = (r_grp_idx == 2'd0) && !r_sync_done;

    always_ff @(posedge clk_50m or posedge clr) begin
        if (clr) begin
            r_grp_idx   <= 2'd0;
            r_sync_done <= 1'b0;
        end else if (r_state == SYNC) begin
            r_sync_done <= 1'b1;
        end else if (r_state == READ) begin
            r_sync_done <= 1'b0;
            r_grp_idx   <= (r_grp_idx == GRP_LAST) ? 2'd0 : r_grp_idx + 2'd1;
        end
    end
`else
    assign w_need_sync = 1'b0;
`endif

    drain_timeout_ctr #(
        .CNT_W(TO_W)
    ) u_timeout (
        .clk       (clk_50m),
        .rst       (clr),
        .i_load    (w_to_load),
        .i_load_val(TO_W'(BUSY_TIMEOUT - 1)),
        .i_dec     (w_to_dec),
        .o_expired (w_to_expired)
    );

    always_ff @(posedge clk_50m or posedge clr) begin
        if (clr) begin
            r_state    <= IDLE;
            r_rdreq    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_tx_data  <= '0;
            r_byte_cnt <= '0;
            r_err      <= 1'b0;
            r_active   <= 1'b0;
            r_lat_cnt  <= 2'd0;
        end else begin
            r_rdreq <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_active <= 1'b1;
                        if (w_need_sync) begin
                            r_state <= SYNC;
                        end else begin
                            r_state <= READ;
                            r_rdreq <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_state   <= LATCH;
                    r_lat_cnt <= 2'd0;
                end
                LATCH: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_tx_data <= drain.fifo_q;
                        r_wr_en   <= 1'b1;
                        r_state   <= SEND;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                SEND: begin
                    r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
                    r_state    <= WAIT_HI;
                end
                // A busy edge wins over expiry in the same cycle.
                WAIT_HI: begin
                    if (drain.tx_busy) begin
                        r_state <= WAIT_LO;
                    end else if (w_to_expired) begin
                        r_err    <= 1'b1;
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                end
                WAIT_LO: begin
                    if (!drain.tx_busy) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                end
`ifdef FIFO_UART_DRAIN_SYNC_EN
                SYNC: begin
                    r_tx_data <= SYNC_BYTE;
                    r_wr_en   <= 1'b1;
                    r_state   <= SEND;
                end
`endif
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign drain.fifo_rdreq  = r_rdreq;
    assign drain.tx_wr_en    = r_wr_en;
    assign drain.tx_data     = r_tx_data;
    assign drain.byte_count  = r_byte_cnt;
    assign drain.err_timeout = r_err;
    assign drain.active      = r_active;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: FIFO and UART behavioural models plus an expected-stream scoreboard.
// Two instances: RD_LATENCY=1 for most sequences, RD_LATENCY=3 for the latency case.
module tb_fifo_uart_drain;

    localparam int         BT     = 64;
    localparam int         GRP    = 4;
    localparam logic [7:0] SYNC_B = 8'hA5;
`ifdef FIFO_UART_DRAIN_SYNC_EN
    localparam int SYNC_ON = 1;
`else
    localparam int SYNC_ON = 0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    fifo_uart_drain_if #(.DATA_W(8)) bus1 ();
    fifo_uart_drain_if #(.DATA_W(8)) bus3 ();

    fifo_uart_drain #(.DATA_W(8), .RD_LATENCY(1), .BUSY_TIMEOUT(BT)) u_dut1 (
        .clk_50m(clk), .clr(clr), .drain(bus1));
    fifo_uart_drain #(.DATA_W(8), .RD_LATENCY(3), .BUSY_TIMEOUT(BT)) u_dut3 (
        .clk_50m(clk), .clr(clr), .drain(bus3));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance 1 environment (latency 1) ----------------
    logic [7:0] fq1[$];
    logic [7:0] exp1[$];
    int   pushed1 = 0, popped1 = 0;
    int   n_data1 = 0, exp_total1 = 0;
    logic [7:0] q1 = 8'h00;
    int   bc1 = 0, busy_len1 = 20;
    bit   never_busy1 = 1'b0;

    assign bus1.fifo_empty = (pushed1 == popped1);
    assign bus1.fifo_q     = q1;
    assign bus1.tx_busy    = (bc1 != 0);

    always @(posedge clk) begin
        if (bus1.fifo_rdreq && fq1.size() > 0) begin
            q1      <= fq1.pop_front();
            popped1 <= popped1 + 1;
        end
        if (bus1.tx_wr_en && !never_busy1) bc1 <= busy_len1;
        else if (bc1 != 0)                 bc1 <= bc1 - 1;
    end

    // Expected stream: data in FIFO order, a delimiter ahead of every GRP-th data byte.
    task automatic push1(input logic [7:0] b);
        if (SYNC_ON != 0 && (n_data1 % GRP) == 0) begin
            exp1.push_back(SYNC_B);
            exp_total1++;
        end
        exp1.push_back(b);
        exp_total1++;
        n_data1++;
        fq1.push_back(b);
        pushed1++;
    endtask

    int   rd_pulses1 = 0, wr_pulses1 = 0, last_wr_cyc1 = 0, err_lat1 = -1;
    logic wr_prev1 = 1'b0, err_prev1 = 1'b0;

    always @(negedge clk) begin
        if (!clr) begin
            if (bus1.fifo_rdreq) begin
                rd_pulses1++;
                chk("rdreq_while_empty", bus1.fifo_empty, 1'b0);
            end
            if (bus1.tx_wr_en) begin
                wr_pulses1++;
                last_wr_cyc1 = cyc;
                chk("wr_en_single_cycle", wr_prev1, 1'b0);
                if (exp1.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h, expected no strobe", bus1.tx_data);
                end else begin
                    chk("tx_data_stream", bus1.tx_data, exp1.pop_front());
                end
            end
            if (bus1.err_timeout && !err_prev1) err_lat1 = cyc - last_wr_cyc1;
        end
        wr_prev1  = bus1.tx_wr_en;
        err_prev1 = bus1.err_timeout;
    end

    task automatic wait_drain1(input int budget, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while ((pushed1 != popped1 || bus1.active || exp1.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_drain_in_budget"}, (k < budget), 1'b1);
    endtask

    // ---------------- instance 3 environment (latency 3) ----------------
    logic [7:0] fq3[$];
    int   pushed3 = 0, popped3 = 0;
    logic [7:0] q3 = 8'hEE;
    logic [8:0] d3a = '0, d3b = '0;
    int   bc3 = 0;
    int   rd_cyc3 = -1, wr_cyc3 = -1;
    logic [7:0] wr_dat3 = 8'h00;

    assign bus3.fifo_empty = (pushed3 == popped3);
    assign bus3.fifo_q     = q3;
    assign bus3.tx_busy    = (bc3 != 0);

    always @(posedge clk) begin
        logic [7:0] v;
        v = 8'h00;
        if (bus3.fifo_rdreq && fq3.size() > 0) begin
            v       = fq3.pop_front();
            popped3 <= popped3 + 1;
        end
        d3a <= {bus3.fifo_rdreq, v};
        d3b <= d3a;
        if (d3b[8]) q3 <= d3b[7:0];
        if (bus3.tx_wr_en) bc3 <= 5;
        else if (bc3 != 0) bc3 <= bc3 - 1;
    end

    always @(negedge clk) begin
        if (bus3.fifo_rdreq && rd_cyc3 < 0) rd_cyc3 = cyc;
        if (bus3.tx_wr_en && rd_cyc3 >= 0 && wr_cyc3 < 0) begin
            wr_cyc3 = cyc;
            wr_dat3 = bus3.tx_data;
        end
    end

    typedef struct {
        logic [7:0] din;
        int         busy;
        logic [7:0] exp_dout;
    } vec_t;
    vec_t vecs [0:4];

    initial begin
        int k, n, cap;
        logic [7:0] rb;

        vecs[0] = '{din: 8'h00, busy: 1,  exp_dout: 8'h00};
        vecs[1] = '{din: 8'hFF, busy: 5,  exp_dout: 8'hFF};
        vecs[2] = '{din: 8'h80, busy: 33, exp_dout: 8'h80};
        vecs[3] = '{din: 8'h01, busy: 2,  exp_dout: 8'h01};
        vecs[4] = '{din: 8'h5C, busy: 12, exp_dout: 8'h5C};

        bus1.enable = 1'b0;
        bus3.enable = 1'b0;
        #2 clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rdreq",   bus1.fifo_rdreq,  1'b0);
        chk("rst_wr_en",   bus1.tx_wr_en,    1'b0);
        chk("rst_tx_data", bus1.tx_data,     8'h00);
        chk("rst_bcount",  bus1.byte_count,  16'h0000);
        chk("rst_err",     bus1.err_timeout, 1'b0);
        chk("rst_active",  bus1.active,      1'b0);
        clr = 1'b0;
        @(negedge clk);

        // Read latency 3: strobe exactly RD_LATENCY+1 cycles after the pop.
        bus3.enable = 1'b1;
        fq3.push_back(8'h5A);
        pushed3++;
        k = 0;
        while (wr_cyc3 < 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("lat3_strobe_seen", (wr_cyc3 >= 0), 1'b1);
        chk("lat3_rdreq_to_wr", wr_cyc3 - rd_cyc3, 4);
        chk("lat3_tx_data",     wr_dat3, 8'h5A);

        // Two preloaded bytes streamed in order.
        busy_len1 = 20;
        push1(8'h12);
        push1(8'h34);
        @(negedge clk);
        bus1.enable = 1'b1;
        wait_drain1(300, "pair");
        chk("pair_rdreq_pulses", rd_pulses1, 2);
        chk("pair_wr_pulses",    wr_pulses1, 2 + SYNC_ON);
        chk("pair_bcount",       bus1.byte_count, 2 + SYNC_ON);
        chk("pair_last_data",    bus1.tx_data, 8'h34);

        for (int i = 0; i < 5; i++) begin
            busy_len1 = vecs[i].busy;
            push1(vecs[i].din);
            wait_drain1(300, "vec");
            chk("vec_tx_data", bus1.tx_data, vecs[i].exp_dout);
            chk("vec_bcount",  bus1.byte_count, exp_total1);
            chk("vec_err",     bus1.err_timeout, 1'b0);
        end

        // enable dropped during WAIT_LO with bytes still queued.
        busy_len1 = 20;
        push1(8'hA1);
        push1(8'hB2);
        push1(8'hC3);
        k = 0;
        while (!bus1.tx_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        bus1.enable = 1'b0;
        k = 0;
        while (bus1.active && k < 200) begin
            @(negedge clk);
            k++;
        end
        cap = rd_pulses1;
        repeat (60) @(negedge clk);
        chk("en_low_no_rdreq", rd_pulses1, cap);
        chk("en_low_idle",     bus1.active, 1'b0);
        chk("en_low_pending",  (pushed1 != popped1), 1'b1);
        bus1.enable = 1'b1;
        wait_drain1(400, "en_resume");
        chk("en_resume_bcount", bus1.byte_count, exp_total1);

        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 5);
            busy_len1 = $urandom_range(2, 30);
            for (int j = 0; j < n; j++) begin
                rb = 8'($urandom);
                push1(rb);
            end
            wait_drain1(100 * (n + 2), "rand");
            chk("rand_bcount", bus1.byte_count, exp_total1);
        end

        // Transmitter never goes busy: sticky timeout, stream keeps moving.
        never_busy1 = 1'b1;
        push1(8'h3C);
        push1(8'hC4);
        wait_drain1(600, "tmo");
        chk("tmo_err_set",    bus1.err_timeout, 1'b1);
        chk("tmo_latency",    err_lat1, BT);
        chk("tmo_bcount",     bus1.byte_count, exp_total1);
        never_busy1 = 1'b0;

        // Asynchronous clear while the byte is in LATCH.
        busy_len1 = 10;
        push1(8'h77);
        k = 0;
        while (!bus1.fifo_rdreq && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("pre_clr_active", bus1.active, 1'b1);
        #1 clr = 1'b1;
        #1;
        chk("clr_rdreq",   bus1.fifo_rdreq,  1'b0);
        chk("clr_wr_en",   bus1.tx_wr_en,    1'b0);
        chk("clr_tx_data", bus1.tx_data,     8'h00);
        chk("clr_bcount",  bus1.byte_count,  16'h0000);
        chk("clr_err",     bus1.err_timeout, 1'b0);
        chk("clr_active",  bus1.active,      1'b0);
        exp1.delete();
        n_data1    = 0;
        exp_total1 = 0;
        rd_pulses1 = 0;
        wr_pulses1 = 0;
        @(negedge clk);
        clr = 1'b0;

        // Eight bytes after clear; with delimiters this is A5,01..04,A5,05..08.
        for (int j = 1; j <= 8; j++) push1(8'(j));
        wait_drain1(800, "grp");
        chk("grp_bcount",    bus1.byte_count, 8 + 2 * SYNC_ON);
        chk("grp_rdreq",     rd_pulses1, 8);
        chk("grp_last_data", bus1.tx_data, 8'h08);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected summary before it");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_uart_drain.md
Name: fifo_uart_drain

Overview:
Sequencer between the dual-clock FIFO's 8-bit read side and the UART transmitter. Pops one byte whenever the FIFO is non-empty and the transmitter is idle, then presents it with a single-cycle write strobe. Waits for the transmitter's busy cycle to complete before the next pop. Replaces manual rdreq/wr_en driving, so LFSR words stream out over UART without operator input.

Parameters:
DATA_W, 8, FIFO read width and UART data width
RD_LATENCY, 1, clk_50m cycles from fifo_rdreq to valid fifo_q (legal range 1-3)
BUSY_TIMEOUT, 64, max cycles to wait for tx_busy to rise after tx_wr_en
GROUP_LEN, 4, bytes per LFSR word (frame size for the optional delimiter)
SYNC_BYTE, 8'hA5, delimiter byte value (optional feature only)

Ports:
clk_50m  in  1  system clock (50 MHz); FIFO read side and UART run on this clock
clr  in  1  asynchronous active-high reset
enable  in  1  level; 0 = finish current byte, then hold in IDLE
fifo_empty  in  1  FIFO rdempty
fifo_q  in  DATA_W  FIFO read data
fifo_rdreq  out  1  FIFO read request, one-cycle pulse
tx_busy  in  1  transmitter busy
tx_data  out  DATA_W  byte to transmitter, held stable through the transfer
tx_wr_en  out  1  transmitter write strobe, one-cycle pulse
byte_count  out  16  bytes handed to the transmitter, wraps 16'hFFFF -> 0
err_timeout  out  1  sticky; set when tx_busy never rose
active  out  1  high in any state other than IDLE

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, fifo_rdreq=0, tx_wr_en=0, tx_data=0, byte_count=0, err_timeout=0, active=0, group index=0. Reset mid-transfer abandons the byte. No recovery of a popped byte.
- IDLE: go to READ when enable=1 and fifo_empty=0 and tx_busy=0. Otherwise stay.
- READ: fifo_rdreq=1 for exactly one cycle, then LATCH.
- LATCH: count RD_LATENCY cycles. On the last one, register tx_data<=fifo_q, then go to SEND.
- SEND: tx_wr_en=1 for exactly one cycle. byte_count increments. Load timeout counter. Go to WAIT_HI.
- WAIT_HI: on tx_busy=1 go to WAIT_LO. If BUSY_TIMEOUT cycles elapse first, set err_timeout and return to IDLE. The byte counts as sent.
- WAIT_LO: on tx_busy=0 go to IDLE. No timeout here; transmitter frame length is fixed.
- Minimum byte-to-byte spacing: one UART frame plus 4+RD_LATENCY cycles.
- fifo_rdreq is never asserted while fifo_empty=1. fifo_empty is sampled in IDLE only. Once READ is entered, the pop completes.
- enable deassertion does not abort: the current byte completes, then the block stays in IDLE.
- err_timeout clears only on clr.
- tx_data is stable from LATCH exit until the next LATCH exit.
- byte_count is 16-bit modular.

Optional Feature:
Macro FIFO_UART_DRAIN_SYNC_EN.
- Defined: a 2-bit group index counts bytes popped from the FIFO. When the index is 0 and a pop is about to start, the block first passes through state SYNC. SYNC loads tx_data=SYNC_BYTE, then runs SEND/WAIT_HI/WAIT_LO as a normal byte, then returns to IDLE with a sync-done flag set so the next pass goes to READ. The index wraps after GROUP_LEN data bytes. byte_count includes sync bytes.
- Undefined: no SYNC state, no group index, and the output stream is data bytes only.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - the state enumeration (IDLE, READ, LATCH, SEND, WAIT_HI, WAIT_LO, SYNC)
  - the default SYNC_BYTE constant
  - the BYTE_CNT_W=16 constant
- One sub-module, drain_timeout_ctr: a loadable down-counter with an expired flag, used in WAIT_HI.
- Everything else stays in fifo_uart_drain.

Test Plan:
- FIFO model preloaded with 0x12,0x34, transmitter model busy 20 cycles after each strobe -> tx_data sequence 0x12 then 0x34; exactly two rdreq pulses and two wr_en pulses; byte_count=2; fifo_rdreq never high while fifo_empty=1.
- RD_LATENCY=3, single byte 0x5A -> tx_wr_en asserts exactly 4 cycles after fifo_rdreq, with tx_data=0x5A.
- Transmitter model never raises tx_busy -> err_timeout=1 exactly BUSY_TIMEOUT cycles after tx_wr_en; the block returns to IDLE and continues with the next byte; err_timeout stays 1.
- enable dropped during WAIT_LO with 3 bytes queued -> current byte completes; no further rdreq while enable=0; streaming resumes when enable=1.
- clr pulsed during LATCH -> all outputs return to reset values asynchronously, before the next clock edge; after release, the next pop proceeds normally.
- With FIFO_UART_DRAIN_SYNC_EN defined, 8 bytes 0x01-0x08 -> output stream A5,01,02,03,04,A5,05,06,07,08; byte_count=10.
